ifetch_unit: RTL and testbench

Instruction fetch unit for the RV32I datapath. It holds the fetch PC and issues word reads to instruction memory over a request/acknowledge handshake. Fetched words are buffered with their PC in a 2-entry queue and handed to the control/decode stage over a valid/ready handshake. Branch, JAL and JALR redirects from execute flush the queue and discard any in-flight read.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/ifetch_queue.sv | 69 ++++++
 rtl/ifetch_unit.sv | 133 +++++++++++++
 tb/tb_ifetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I datapath types: reset vector, NOP encoding, fetch FSM states
// and the instruction-queue entry layout.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Two-entry instruction queue. Slot 0 is always the head, so head outputs come
// straight from a register; an empty head shows a NOP and keeps its last PC.
module ifetch_queue
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         head_valid,
    output fetch_entry_t head
);

    fetch_entry_t slot0_r;
    fetch_entry_t slot1_r;
    logic         valid0_r;
    logic         valid1_r;
    logic         do_pop_s;

    assign do_pop_s   = pop & valid0_r;
    assign count      = {1'b0, valid0_r} + {1'b0, valid1_r};
    assign head_valid = valid0_r;
    assign head       = slot0_r;

    // Shift-style FIFO update; flush beats push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid0_r <= 1'b0;
            valid1_r <= 1'b0;
            slot0_r  <= {NOP_INSTR, 32'h0000_0000};
            slot1_r  <= {NOP_INSTR, 32'h0000_0000};
        end else if (flush) begin
            valid0_r      <= 1'b0;
            valid1_r      <= 1'b0;
            slot0_r.instr <= NOP_INSTR;
        end else if (do_pop_s && push) begin
            if (valid1_r) begin
                slot0_r <= slot1_r;
                slot1_r <= push_entry;
            end else begin
                slot0_r <= push_entry;
            end
        end else if (do_pop_s) begin
            if (valid1_r) begin
                slot0_r  <= slot1_r;
                valid1_r <= 1'b0;
            end else begin
                valid0_r      <= 1'b0;
                slot0_r.instr <= NOP_INSTR;
            end
        end else if (push) begin
            if (!valid0_r) begin
                slot0_r  <= push_entry;
                valid0_r <= 1'b1;
            end else if (!valid1_r) begin
                slot1_r  <= push_entry;
                valid1_r <= 1'b1;
            end else begin
                slot1_r <= slot1_r;
            end
        end else begin
            slot0_r <= slot0_r;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch: single-outstanding request/ack memory port feeding a
// 2-entry queue toward decode, with execute-stage redirects flushing everything.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    output logic        oIMemReq,
    output logic [31:0] oIMemAddr,
    input  logic        iIMemAck,
    input  logic [31:0] iIMemData,
    output logic        oValid,
    input  logic        iReady,
    output logic [31:0] oInstr,
    output logic [31:0] oPC,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPC,
    output logic        oMisaligned
);

    localparam logic [1:0] QFULL = 2'(QDEPTH);

    fetch_state_e state_r;
    logic [31:0]  fetch_pc_r;
    logic [31:0]  addr_r;
    logic         req_r;
    logic         mis_r;

    logic [1:0]   q_count_s;
    logic         q_valid_s;
    fetch_entry_t q_head_s;
    fetch_entry_t push_entry_s;
    logic         pop_s;
    logic         push_s;
    logic [1:0]   count_next_s;
    logic         slot_free_s;
    logic [31:0]  target_s;
    logic [31:0]  pc_inc_s;

    // A pop coinciding with a redirect is swallowed by the flush anyway.
    assign pop_s        = q_valid_s & iReady & ~iRedirect;
    assign push_s       = (state_r == REQ) & iIMemAck & ~iRedirect;
    assign count_next_s = q_count_s + {1'b0, push_s} - {1'b0, pop_s};
    assign slot_free_s  = (count_next_s < QFULL);
    assign target_s     = word_align(iRedirectPC);
    assign pc_inc_s     = fetch_pc_r + 32'd4;
    assign push_entry_s = {iIMemData, fetch_pc_r};

    ifetch_queue u_queue (
        .clk        (iCLK),
        .rst_n      (iRSTn),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (iRedirect),
        .count      (q_count_s),
        .head_valid (q_valid_s),
        .head       (q_head_s)
    );

    // Fetch FSM: the request address must not move while a read is outstanding,
    // so a redirect during a wait parks in DROP until the stale ack arrives.
    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            addr_r     <= RESET_PC;
            req_r      <= 1'b0;
            mis_r      <= 1'b0;
        end else if (iRedirect) begin
            fetch_pc_r <= target_s;
            mis_r      <= (iRedirectPC[1:0] != 2'b00);
            if ((state_r != IDLE) && !iIMemAck) begin
                state_r <= DROP;
            end else begin
                state_r <= REQ;
                req_r   <= 1'b1;
                addr_r  <= target_s;
            end
        end else begin
            mis_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (slot_free_s) begin
                        state_r <= REQ;
                        req_r   <= 1'b1;
                        addr_r  <= fetch_pc_r;
                    end else begin
                        req_r <= 1'b0;
                    end
                end
                REQ: begin
                    if (iIMemAck) begin
                        fetch_pc_r <= pc_inc_s;
                        addr_r     <= pc_inc_s;
                        if (slot_free_s) begin
                            state_r <= REQ;
                        end else begin
                            state_r <= IDLE;
                            req_r   <= 1'b0;
                        end
                    end else begin
                        state_r <= REQ;
                    end
                end
                DROP: begin
                    if (iIMemAck) begin
                        state_r <= REQ;
                        addr_r  <= fetch_pc_r;
                    end else begin
                        state_r <= DROP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                    addr_r  <= fetch_pc_r;
                end
            endcase
        end
    end

    assign oIMemReq    = req_r;
    assign oIMemAddr   = addr_r;
    assign oValid      = q_valid_s;
    assign oInstr      = q_head_s.instr;
    assign oPC         = q_head_s.pc;
    assign oMisaligned = mis_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios then random traffic, all checked
// against an occupancy/stream model of the fetch unit.
module tb_ifetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        iCLK = 1'b0;
    logic        iRSTn = 1'b0;
    logic        oIMemReq;
    logic [31:0] oIMemAddr;
    logic        iIMemAck = 1'b0;
    logic [31:0] iIMemData = 32'h0000_0000;
    logic        oValid;
    logic        iReady = 1'b0;
    logic [31:0] oInstr;
    logic [31:0] oPC;
    logic        iRedirect = 1'b0;
    logic [31:0] iRedirectPC = 32'h0000_0000;
    logic        oMisaligned;

    ifetch_unit #(.RESET_PC(RPC), .QDEPTH(2)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn),
        .oIMemReq(oIMemReq), .oIMemAddr(oIMemAddr),
        .iIMemAck(iIMemAck), .iIMemData(iIMemData),
        .oValid(oValid), .iReady(iReady), .oInstr(oInstr), .oPC(oPC),
        .iRedirect(iRedirect), .iRedirectPC(iRedirectPC),
        .oMisaligned(oMisaligned)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;

    // Model: expected decode stream, expected fetch address, entries held.
    logic [31:0] exp_pc, exp_fetch, drop_addr;
    int          buffered;
    logic        dropping, mis_exp, req_exp;

    // Memory environment.
    int   wait_cnt = 0;
    int   lat = 0;
    bit   lat_rand = 1'b0;
    bit   force_ack = 1'b0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc    = RPC;
        exp_fetch = RPC;
        drop_addr = RPC;
        buffered  = 0;
        dropping  = 1'b0;
        mis_exp   = 1'b0;
        req_exp   = 1'b0;
        wait_cnt  = 0;
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        iRSTn = 1'b0; iReady = 1'b0; iRedirect = 1'b0; iIMemAck = 1'b0;
        @(posedge iCLK); #1;
        check1 ("rst_req",   oIMemReq,    1'b0);
        check32("rst_addr",  oIMemAddr,   RPC);
        check1 ("rst_valid", oValid,      1'b0);
        check32("rst_instr", oInstr,      NOP_INSTR);
        check32("rst_pc",    oPC,         32'h0000_0000);
        check1 ("rst_mis",   oMisaligned, 1'b0);
        model_reset();
    endtask

    task automatic cyc(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic [31:0] out_addr;
        @(negedge iCLK);
        iRSTn = 1'b1; iReady = rdy; iRedirect = redir; iRedirectPC = rpc;
        if (force_ack) begin
            iIMemAck = 1'b1; iIMemData = 32'hDEAD_BEEF; force_ack = 1'b0;
        end else if (oIMemReq === 1'b1 && wait_cnt >= lat) begin
            iIMemAck = 1'b1; iIMemData = memw(oIMemAddr); wait_cnt = 0;
            if (lat_rand) lat = $urandom_range(0, 3);
        end else begin
            iIMemAck = 1'b0; iIMemData = $urandom;
            if (oIMemReq === 1'b1) wait_cnt++; else wait_cnt = 0;
        end
        out_addr = dropping ? drop_addr : exp_fetch;
        if (oValid === 1'b1 && rdy && !redir) begin
            check32("pop_pc", oPC, exp_pc);
            check32("pop_instr", oInstr, memw(exp_pc));
            exp_pc = exp_pc + 32'd4;
            buffered--;
        end
        if (req_exp && iIMemAck && !redir && !dropping) begin
            buffered++;
            exp_fetch = exp_fetch + 32'd4;
        end
        if (req_exp && iIMemAck) dropping = 1'b0;
        if (redir) begin
            buffered  = 0;
            exp_pc    = rpc & 32'hFFFF_FFFC;
            exp_fetch = rpc & 32'hFFFF_FFFC;
            mis_exp   = (rpc[1:0] != 2'b00);
            if (req_exp && !iIMemAck) begin
                dropping  = 1'b1;
                drop_addr = out_addr;
            end
        end else begin
            mis_exp = 1'b0;
        end
        req_exp = dropping || (buffered < 2);
        @(posedge iCLK); #1;
        check1("valid", oValid, buffered != 0);
        if (buffered == 0) check32("empty_nop", oInstr, NOP_INSTR);
        check1("misaligned", oMisaligned, mis_exp);
        check1("req", oIMemReq, req_exp);
        if (dropping) check32("drop_addr", oIMemAddr, drop_addr);
        else if (req_exp) check32("req_addr", oIMemAddr, exp_fetch);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc_exp);
        for (int i = 0; i < 12; i++) begin
            if (oValid === 1'b1) break;
            cyc(1'b1, 1'b0, 32'h0);
        end
        check1({tag, "_valid"}, oValid, 1'b1);
        check32({tag, "_pc"}, oPC, pc_exp);
    endtask

    initial begin
        logic        rdy, redir;
        logic [31:0] rpc;
        model_reset();

        // Zero-wait streaming from reset: one address per cycle, no bubbles.
        do_reset();
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, 1'b0, 32'h0);
            check32("t1_addr", oIMemAddr, RPC + 32'(4 * (k - 1)));
            if (k >= 2) begin
                check1("t1_nobubble", oValid, 1'b1);
                check32("t1_pc", oPC, RPC + 32'(4 * (k - 2)));
            end
        end

        // Decode stalls: two words buffered, fetch stops, then resumes at +8.
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        check1("t2_req_low", oIMemReq, 1'b0);
        check32("t2_head", oPC, RPC + 32'd16);
        cyc(1'b1, 1'b0, 32'h0);
        check32("t2_resume_addr", oIMemAddr, RPC + 32'd24);
        check32("t2_second_pc", oPC, RPC + 32'd20);
        cyc(1'b1, 1'b0, 32'h0);
        check32("t2_third_pc", oPC, RPC + 32'd24);

        // Slow memory, redirect during the wait: address held, stale data dropped.
        do_reset();
        lat = 3;
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, RPC + 32'h100);
        check32("t3_hold", oIMemAddr, RPC);
        cyc(1'b1, 1'b0, 32'h0);
        check32("t3_hold2", oIMemAddr, RPC);
        cyc(1'b1, 1'b0, 32'h0);
        check32("t3_new_addr", oIMemAddr, RPC + 32'h100);
        check1("t3_dropped", oValid, 1'b0);
        wait_valid("t3_first", RPC + 32'h100);

        // Redirect together with ack and pop.
        lat = 0;
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, RPC + 32'h200);
        check1("t4_flushed", oValid, 1'b0);
        check32("t4_addr", oIMemAddr, RPC + 32'h200);
        cyc(1'b1, 1'b0, 32'h0);
        check32("t4_pc", oPC, RPC + 32'h200);

        // Misaligned redirect target.
        cyc(1'b1, 1'b1, RPC + 32'h102);
        check1("t5_mis_high", oMisaligned, 1'b1);
        check32("t5_addr", oIMemAddr, RPC + 32'h100);
        cyc(1'b1, 1'b0, 32'h0);
        check1("t5_mis_low", oMisaligned, 1'b0);
        check32("t5_pc", oPC, RPC + 32'h100);

        // Fetch PC wraps past the top of the address space.
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
        check32("t6_top_addr", oIMemAddr, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 32'h0);
        check32("t6_wrap_addr", oIMemAddr, 32'h0000_0000);
        check32("t6_top_pc", oPC, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 32'h0);
        check32("t6_wrap_pc", oPC, 32'h0000_0000);

        // Reset with a read pending, then a late ack that must be ignored.
        lat = 3;
        cyc(1'b1, 1'b0, 32'h0);
        do_reset();
        force_ack = 1'b1;
        cyc(1'b1, 1'b0, 32'h0);
        check1("t6_late_ack", oValid, 1'b0);
        check32("t6_restart_addr", oIMemAddr, RPC);
        wait_valid("t6_restart", RPC);

        // Random traffic: variable latency, stalls, redirects.
        lat_rand = 1'b1;
        for (int n = 0; n < 800; n++) begin
            rdy   = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) rpc = $urandom;
            else rpc = RPC + 32'($urandom_range(0, 1023));
            cyc(rdy, redir, rpc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
